// File: rtl/pq_pkg.sv
// Shared types for the hardware priority queue and the client scheduler in front of it.
package pq_pkg;

  localparam int KEY_W       = 8;
  localparam int VAL_W       = 8;
  localparam int PQ_CAPACITY = 8;
  // The queue returns the smallest key first.
  localparam bit MIN_PQ      = 1'b1;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  // All-ones key marks an empty slot, so it can never be stored.
  localparam logic [KEY_W-1:0] KEYINF   = '1;
  localparam kv_t              KV_EMPTY = '{key: KEYINF, val: '0};

  // Bit 0 drives the enqueue strobe and bit 1 the dequeue strobe; both together mean replace.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_REPL = 2'b11
  } pq_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } sched_state_t;

endpackage

// File: rtl/pq_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or after rr_ptr, wrapping.
module pq_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW:0] w_slot;

  // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_slot    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_slot = {1'b0, rr_ptr} + (IW+1)'(k);
      if (w_slot >= (IW+1)'(NREQ)) begin
        w_slot = w_slot - (IW+1)'(NREQ);
      end
      if (req[w_slot[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pq_sched.sv
// Shares one priority queue between NREQ clients: round-robin grant, legality check
// against a local occupancy count, PQ strobe/busy sequencing and a registered response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | arbitrate; legal grant -> S_ISSUE, illegal grant -> S_RESP
// S_ISSUE | PQ strobes high for this one cycle; pre-operation top sampled
// S_WAIT  | hold until pq_busy is low, then load the response
// S_RESP  | req_ack[g] high; count and rr_ptr advance on the way out
module pq_sched
  import pq_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int CAPACITY = PQ_CAPACITY,
  localparam int IW       = $clog2(NREQ),
  localparam int CW       = $clog2(CAPACITY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  pq_op_t [NREQ-1:0]     req_op,
  input  kv_t [NREQ-1:0]        req_kv,
  output logic [NREQ-1:0]       req_ack,
  output kv_t                   rsp_kv,
  output logic                  rsp_err,
  output logic                  pq_enq,
  output logic                  pq_deq,
  output kv_t                   pq_kvi,
  input  kv_t                   pq_kvo,
  input  logic                  pq_busy,
  output logic [CW-1:0]         count,
  output logic                  sched_busy
);

  sched_state_t    r_state;
  sched_state_t    w_nxt_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_gnt;
  pq_op_t          r_op;
  kv_t             r_top;
  logic [CW-1:0]   r_count;
  logic [NREQ-1:0] r_ack;
  kv_t             r_rsp_kv;
  logic            r_rsp_err;
  logic            r_pq_enq;
  logic            r_pq_deq;
  kv_t             r_pq_kvi;
  logic            r_sched_busy;

  logic            w_gnt_valid;
  logic [IW-1:0]   w_gnt_idx;
  pq_op_t          w_op;
  kv_t             w_kv;
  logic            w_illegal;
  logic            w_grant;

  pq_rr_arb #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_op    = req_op[w_gnt_idx];
  assign w_kv    = req_kv[w_gnt_idx];
  assign w_grant = (r_state == S_IDLE) && w_gnt_valid;

  // Reject requests the queue cannot honour given the current occupancy.
  always_comb begin
    w_illegal = 1'b0;
    case (w_op)
      OP_NOP:  w_illegal = 1'b1;
      OP_ENQ:  w_illegal = (r_count == CW'(CAPACITY)) || (w_kv.key == KEYINF);
      OP_DEQ:  w_illegal = (r_count == '0);
      OP_REPL: w_illegal = (r_count == '0) || (w_kv.key == KEYINF);
      default: w_illegal = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_valid) w_nxt_state = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: w_nxt_state = S_WAIT;
      S_WAIT:  if (!pq_busy) w_nxt_state = S_RESP;
      S_RESP:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State register; sched_busy is registered from the next state so it tracks r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sched_busy <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_sched_busy <= (w_nxt_state != S_IDLE);
    end
  end

  // Latch the granted client and its op; the request lines may go away after the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_op  <= OP_NOP;
    end else if (w_grant) begin
      r_gnt <= w_gnt_idx;
      r_op  <= w_op;
    end
  end

  // PQ strobes and input pair are high only in S_ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pq_enq <= 1'b0;
      r_pq_deq <= 1'b0;
      r_pq_kvi <= KV_EMPTY;
    end else begin
      r_pq_enq <= 1'b0;
      r_pq_deq <= 1'b0;
      r_pq_kvi <= KV_EMPTY;
      if (w_grant && !w_illegal) begin
        r_pq_enq <= (w_op == OP_ENQ) || (w_op == OP_REPL);
        r_pq_deq <= (w_op == OP_DEQ) || (w_op == OP_REPL);
        r_pq_kvi <= w_kv;
      end
    end
  end

  // The top seen during S_ISSUE is the pre-operation minimum returned by DEQ/REPL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top <= KV_EMPTY;
    end else if (r_state == S_ISSUE) begin
      r_top <= pq_kvo;
    end
  end

  // Response: ack pulse for one cycle; kv/err hold until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack     <= '0;
      r_rsp_kv  <= KV_EMPTY;
      r_rsp_err <= 1'b0;
    end else begin
      r_ack <= '0;
      if (w_grant && w_illegal) begin
        r_ack     <= NREQ'(1) << w_gnt_idx;
        r_rsp_kv  <= KV_EMPTY;
        r_rsp_err <= 1'b1;
      end else if ((r_state == S_WAIT) && !pq_busy) begin
        r_ack     <= NREQ'(1) << r_gnt;
        r_rsp_kv  <= (r_op == OP_ENQ) ? KV_EMPTY : r_top;
        r_rsp_err <= 1'b0;
      end
    end
  end

  // Occupancy and round-robin pointer advance as S_RESP completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else if (r_state == S_RESP) begin
      r_rr_ptr <= (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
      if (!r_rsp_err) begin
        if ((r_op == OP_ENQ) && (r_count != CW'(CAPACITY))) begin
          r_count <= r_count + 1'b1;
        end else if ((r_op == OP_DEQ) && (r_count != '0)) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  assign req_ack    = r_ack;
  assign rsp_kv     = r_rsp_kv;
  assign rsp_err    = r_rsp_err;
  assign pq_enq     = r_pq_enq;
  assign pq_deq     = r_pq_deq;
  assign pq_kvi     = r_pq_kvi;
  assign count      = r_count;
  assign sched_busy = r_sched_busy;

endmodule

// File: tb/tb_pq_sched.sv
// Directed bench for pq_sched with a behavioural min-priority queue behind it.
module tb_pq_sched;
  import pq_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = $clog2(PQ_CAPACITY + 1);

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  pq_op_t [NREQ-1:0] req_op;
  kv_t [NREQ-1:0]  req_kv;
  logic [NREQ-1:0] req_ack;
  kv_t             rsp_kv;
  logic            rsp_err;
  logic            pq_enq;
  logic            pq_deq;
  kv_t             pq_kvi;
  kv_t             pq_kvo;
  logic            pq_busy;
  logic [CW-1:0]   count;
  logic            sched_busy;

  int n_chk  = 0;
  int n_fail = 0;

  pq_sched #(.NREQ(NREQ), .CAPACITY(PQ_CAPACITY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_kv     (req_kv),
    .req_ack    (req_ack),
    .rsp_kv     (rsp_kv),
    .rsp_err    (rsp_err),
    .pq_enq     (pq_enq),
    .pq_deq     (pq_deq),
    .pq_kvi     (pq_kvi),
    .pq_kvo     (pq_kvo),
    .pq_busy    (pq_busy),
    .count      (count),
    .sched_busy (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural min-PQ: updates on the strobe edge, busy for busy_lat cycles afterwards.
  kv_t m_mem [16];
  kv_t m_tmp [16];
  int  m_n;
  int  m_tn;
  int  m_mi;
  int  m_bcnt;
  int  busy_lat = 0;
  kv_t m_best;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n    <= 0;
      m_bcnt <= 0;
    end else begin
      m_tmp = m_mem;
      m_tn  = m_n;
      if (pq_deq && m_tn > 0) begin
        m_mi = 0;
        for (int i = 1; i < 16; i++)
          if (i < m_tn && m_tmp[i].key < m_tmp[m_mi].key) m_mi = i;
        for (int i = 0; i < 15; i++)
          if (i >= m_mi) m_tmp[i] = m_tmp[i+1];
        m_tn = m_tn - 1;
      end
      if (pq_enq && m_tn < 16) begin
        m_tmp[m_tn] = pq_kvi;
        m_tn = m_tn + 1;
      end
      m_mem <= m_tmp;
      m_n   <= m_tn;
      if (pq_enq || pq_deq) m_bcnt <= busy_lat;
      else if (m_bcnt > 0)  m_bcnt <= m_bcnt - 1;
    end
  end

  always_comb begin
    m_best = KV_EMPTY;
    for (int i = 0; i < 16; i++)
      if (i < m_n && m_mem[i].key < m_best.key) m_best = m_mem[i];
  end

  assign pq_kvo  = m_best;
  assign pq_busy = (m_bcnt != 0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic kv_t mk(input int k, input int v);
    kv_t r;
    r.key = k[KEY_W-1:0];
    r.val = v[VAL_W-1:0];
    return r;
  endfunction

  // Issue one request from client c, starting in the current cycle (cycle 0).
  // Reports the cycle of the ack and of each strobe (-1 if never seen), then
  // steps one extra cycle so the caller resumes in IDLE.
  task automatic do_req(input int c, input pq_op_t op, input kv_t kv,
                        output int lat, output int enq_cyc, output int deq_cyc,
                        output kv_t kvi_seen, output logic err, output kv_t rkv,
                        output logic busy1);
    lat = -1; enq_cyc = -1; deq_cyc = -1;
    kvi_seen = KV_EMPTY; err = 1'b0; rkv = KV_EMPTY; busy1 = 1'b0;
    req_op[c]    = op;
    req_kv[c]    = kv;
    req_valid[c] = 1'b1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) busy1 = sched_busy;
      if (pq_enq && enq_cyc < 0) begin enq_cyc = n; kvi_seen = pq_kvi; end
      if (pq_deq && deq_cyc < 0) begin deq_cyc = n; kvi_seen = pq_kvi; end
      if (req_ack[c]) begin
        lat = n; err = rsp_err; rkv = rsp_kv;
        req_valid[c] = 1'b0;
      end
    end
    req_valid[c] = 1'b0;
    @(posedge clk); #1;
  endtask

  int   lat, ec, dc;
  kv_t  kvi, rkv;
  logic err, b1;
  kv_t  fill_tbl [7];
  int   ack_idx [5];
  int   ack_cyc [5];
  int   n_ack;
  logic reassert;
  logic any_ack;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '{default: OP_NOP};
    req_kv    = '{default: KV_EMPTY};
    fill_tbl[0] = mk(8, 8);  fill_tbl[1] = mk(6, 6);  fill_tbl[2] = mk(3, 7);
    fill_tbl[3] = mk(9, 9);  fill_tbl[4] = mk(4, 4);  fill_tbl[5] = mk(7, 7);
    fill_tbl[6] = mk(10, 10);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack",   32'(req_ack),    32'h0);
    check_eq("rst_err",   32'(rsp_err),    32'h0);
    check_eq("rst_kv",    32'(rsp_kv),     32'(KV_EMPTY));
    check_eq("rst_enq",   32'(pq_enq),     32'h0);
    check_eq("rst_deq",   32'(pq_deq),     32'h0);
    check_eq("rst_kvi",   32'(pq_kvi),     32'(KV_EMPTY));
    check_eq("rst_count", 32'(count),      32'h0);
    check_eq("rst_busy",  32'(sched_busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // DEQ on an empty queue is rejected at cycle 1 with no strobe
    do_req(1, OP_DEQ, mk(0, 0), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("deq_empty_lat",   32'(lat),   32'd1);
    check_eq("deq_empty_err",   32'(err),   32'd1);
    check_eq("deq_empty_kv",    32'(rkv),   32'(KV_EMPTY));
    check_eq("deq_empty_strobe", 32'(dc),   32'hFFFF_FFFF);
    check_eq("deq_empty_count", 32'(count), 32'd0);

    // First legal ENQ: strobe at cycle 1, ack at cycle 3
    do_req(0, OP_ENQ, mk(5, 1), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("enq_strobe_cyc", 32'(ec),    32'd1);
    check_eq("enq_kvi",        32'(kvi),   32'(mk(5, 1)));
    check_eq("enq_no_deq",     32'(dc),    32'hFFFF_FFFF);
    check_eq("enq_lat",        32'(lat),   32'd3);
    check_eq("enq_err",        32'(err),   32'd0);
    check_eq("enq_kv",         32'(rkv),   32'(KV_EMPTY));
    check_eq("enq_sched_busy", 32'(b1),    32'd1);
    check_eq("enq_count",      32'(count), 32'd1);

    do_req(2, OP_NOP, mk(1, 1), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("nop_lat", 32'(lat), 32'd1);
    check_eq("nop_err", 32'(err), 32'd1);

    do_req(3, OP_ENQ, KV_EMPTY, lat, ec, dc, kvi, err, rkv, b1);
    check_eq("enq_inf_err",    32'(err),   32'd1);
    check_eq("enq_inf_strobe", 32'(ec),    32'hFFFF_FFFF);
    check_eq("enq_inf_count",  32'(count), 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_req(i % 4, OP_ENQ, fill_tbl[i], lat, ec, dc, kvi, err, rkv, b1);
      check_eq("fill_err", 32'(err), 32'd0);
    end
    check_eq("fill_count", 32'(count), 32'(PQ_CAPACITY));

    do_req(1, OP_ENQ, mk(2, 2), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("full_err",    32'(err),   32'd1);
    check_eq("full_strobe", 32'(ec),    32'hFFFF_FFFF);
    check_eq("full_count",  32'(count), 32'(PQ_CAPACITY));

    do_req(1, OP_DEQ, mk(0, 0), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("deq_min_kv",    32'(rkv),   32'(mk(3, 7)));
    check_eq("deq_min_lat",   32'(lat),   32'd3);
    check_eq("deq_min_cyc",   32'(dc),    32'd1);
    check_eq("deq_min_count", 32'(count), 32'(PQ_CAPACITY - 1));

    do_req(0, OP_ENQ, mk(3, 7), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("refill_count", 32'(count), 32'(PQ_CAPACITY));

    // REPL returns old top, both strobes in the same cycle, count unchanged
    do_req(2, OP_REPL, mk(9, 2), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("repl_kv",    32'(rkv),   32'(mk(3, 7)));
    check_eq("repl_err",   32'(err),   32'd0);
    check_eq("repl_enq",   32'(ec),    32'd1);
    check_eq("repl_deq",   32'(dc),    32'd1);
    check_eq("repl_kvi",   32'(kvi),   32'(mk(9, 2)));
    check_eq("repl_count", 32'(count), 32'(PQ_CAPACITY));

    do_req(3, OP_DEQ, mk(0, 0), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("deq2_kv",    32'(rkv),   32'(mk(4, 4)));
    check_eq("deq2_count", 32'(count), 32'(PQ_CAPACITY - 1));

    // PQ busy for 5 cycles pushes the ack to cycle 8
    busy_lat = 5;
    do_req(0, OP_DEQ, mk(0, 0), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("busy_lat",   32'(lat),   32'd8);
    check_eq("busy_kv",    32'(rkv),   32'(mk(5, 1)));
    check_eq("busy_count", 32'(count), 32'(PQ_CAPACITY - 2));
    busy_lat = 0;

    // Round robin: all clients request from reset, client 0 comes back after its ack
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < NREQ; c++) begin
      req_op[c] = OP_ENQ;
      req_kv[c] = mk(20 + c, c);
    end
    req_valid = '1;
    n_ack    = 0;
    reassert = 1'b0;
    for (int n = 1; n <= 60 && n_ack < 5; n++) begin
      @(posedge clk); #1;
      if (reassert) begin
        req_kv[0]    = mk(24, 4);
        req_valid[0] = 1'b1;
        reassert     = 1'b0;
      end
      for (int c = 0; c < NREQ; c++) begin
        if (req_ack[c] && n_ack < 5) begin
          ack_idx[n_ack] = c;
          ack_cyc[n_ack] = n;
          if (c == 0 && n_ack == 0) reassert = 1'b1;
          req_valid[c] = 1'b0;
          n_ack = n_ack + 1;
        end
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
    check_eq("rr_nacks", 32'(n_ack), 32'd5);
    check_eq("rr_0", 32'(ack_idx[0]), 32'd0);
    check_eq("rr_1", 32'(ack_idx[1]), 32'd1);
    check_eq("rr_2", 32'(ack_idx[2]), 32'd2);
    check_eq("rr_3", 32'(ack_idx[3]), 32'd3);
    check_eq("rr_4", 32'(ack_idx[4]), 32'd0);
    check_eq("rr_first_cyc", 32'(ack_cyc[0]), 32'd3);
    check_eq("rr_spacing",   32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
    check_eq("rr_last_cyc",  32'(ack_cyc[4]), 32'd19);
    check_eq("rr_count", 32'(count), 32'd5);

    // Reset in WAIT aborts with no ack and clears every output
    busy_lat = 5;
    req_op[2]    = OP_DEQ;
    req_kv[2]    = mk(0, 0);
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_issue_deq", 32'(pq_deq), 32'd1);
    @(posedge clk); #1;
    check_eq("abort_wait_busy", 32'(sched_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    req_valid = '0;
    check_eq("abort_ack",   32'(req_ack),    32'h0);
    check_eq("abort_err",   32'(rsp_err),    32'h0);
    check_eq("abort_kv",    32'(rsp_kv),     32'(KV_EMPTY));
    check_eq("abort_enq",   32'(pq_enq),     32'h0);
    check_eq("abort_deq",   32'(pq_deq),     32'h0);
    check_eq("abort_kvi",   32'(pq_kvi),     32'(KV_EMPTY));
    check_eq("abort_count", 32'(count),      32'h0);
    check_eq("abort_busy",  32'(sched_busy), 32'h0);
    any_ack = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      any_ack = any_ack | (|req_ack);
    end
    rst_n    = 1'b1;
    busy_lat = 0;
    @(posedge clk); #1;
    any_ack = any_ack | (|req_ack);
    check_eq("abort_no_ack", 32'(any_ack), 32'd0);

    do_req(1, OP_ENQ, mk(12, 3), lat, ec, dc, kvi, err, rkv, b1);
    check_eq("post_rst_lat",   32'(lat),   32'd3);
    check_eq("post_rst_count", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
